// File: rtl/sync_fifo_flags.sv
// ============================================================================
// Module   : sync_fifo_flags
// Purpose  : Parametrised single-clock FIFO with an exact fill count,
//            full/empty/almost flags, read-valid strobe and sticky
//            overflow/underflow error flags.
// Options  : FIFO_FWFT_EN - when defined, first-word-fall-through read
//            (combinational o_rddata, i_rden acts as a pop acknowledge).
//            When undefined, registered read with one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_flags #(
  parameter int WIDTH     = 128,
  parameter int DEPTH     = 1024,
  parameter int ADDRESS   = 10,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 2
) (
  input  logic               clk,
  input  logic               rstn,        // active-high synchronous reset
  input  logic [WIDTH-1:0]   i_wrdata,
  input  logic               i_wren,
  input  logic               i_rden,
  input  logic               i_clr_err,
  output logic [WIDTH-1:0]   o_rddata,
  output logic               o_rdvalid,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_alm_full,
  output logic               o_alm_empty,
  output logic [ADDRESS:0]   o_count,
  output logic               o_overflow,
  output logic               o_underflow
);

  // Occupancy thresholds expressed at the count width.
  localparam logic [ADDRESS:0] FULL_LEVEL = (ADDRESS+1)'(DEPTH);
  localparam logic [ADDRESS:0] AF_LEVEL   = (ADDRESS+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDRESS:0] AE_LEVEL   = (ADDRESS+1)'(AE_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [ADDRESS:0] wr_ptr;
  logic [ADDRESS:0] rd_ptr;
  logic [ADDRESS:0] count;
  logic             wr_accept;
  logic             rd_accept;

  // Count wraps modulo 2^(ADDRESS+1), which is exactly the pointer distance.
  assign count       = wr_ptr - rd_ptr;
  assign o_count     = count;
  assign o_full      = (count == FULL_LEVEL);
  assign o_empty     = (count == '0);
  assign o_alm_full  = (count >= AF_LEVEL);
  assign o_alm_empty = (count <= AE_LEVEL);

  // A blocked request is simply dropped; it never moves a pointer.
  assign wr_accept = i_wren && !o_full;
  assign rd_accept = i_rden && !o_empty;

  // Pointer update; reset discards all stored data.
  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rstn && wr_accept) begin
      mem[wr_ptr[ADDRESS-1:0]] <= i_wrdata;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is always visible; a read simply acknowledges it.
  assign o_rddata  = mem[rd_ptr[ADDRESS-1:0]];
  assign o_rdvalid = !o_empty;
`else
  // Registered read: popped word appears one cycle after the accepted read.
  always_ff @(posedge clk) begin
    if (rstn) begin
      o_rddata  <= '0;
      o_rdvalid <= 1'b0;
    end else begin
      o_rdvalid <= rd_accept;
      if (rd_accept) o_rddata <= mem[rd_ptr[ADDRESS-1:0]];
    end
  end
`endif

  // Sticky error flags; a new error in the same cycle beats the clear.
  always_ff @(posedge clk) begin
    if (rstn) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wren && o_full)  o_overflow <= 1'b1;
      else if (i_clr_err)    o_overflow <= 1'b0;
      if (i_rden && o_empty) o_underflow <= 1'b1;
      else if (i_clr_err)    o_underflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO. Generalises the fixed 128x1024 buffer to configurable width, depth and almost-full/almost-empty margins.
- Adds an exact fill count, a read-valid strobe, and sticky overflow/underflow error flags with a clear input.
- Sits between a producer and a consumer in the same clock domain; it is the standard buffering primitive for datapath stages.

Parameters:
- WIDTH, 128, data word width in bits.
- DEPTH, 1024, number of entries; must be a power of two and at least 4.
- ADDRESS, 10, address width; must equal log2(DEPTH).
- AF_MARGIN, 4, o_alm_full asserts when count >= DEPTH-AF_MARGIN; legal range 1..DEPTH-1.
- AE_MARGIN, 2, o_alm_empty asserts when count <= AE_MARGIN; legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  synchronous, active-high reset (reset when rstn==1), despite the name.
- i_wrdata  input  WIDTH  write data.
- i_wren  input  1  write request.
- i_rden  input  1  read request.
- i_clr_err  input  1  clears o_overflow and o_underflow.
- o_rddata  output  WIDTH  read data.
- o_rdvalid  output  1  o_rddata carries a newly popped word this cycle.
- o_full  output  1  count == DEPTH.
- o_empty  output  1  count == 0.
- o_alm_full  output  1  count >= DEPTH-AF_MARGIN.
- o_alm_empty  output  1  count <= AE_MARGIN.
- o_count  output  ADDRESS+1  current occupancy, 0..DEPTH.
- o_overflow  output  1  sticky: a write was attempted while full.
- o_underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rstn==1 at a clock edge):
  - Pointers, count, o_rddata, o_rdvalid, o_overflow and o_underflow all go to 0.
  - Consequently o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data. Requests presented in the reset cycle are ignored.
- Pointers and count:
  - wr_ptr and rd_ptr are ADDRESS+1 bits. The MSB is a wrap bit; the memory index is the low ADDRESS bits.
  - Pointers wrap naturally modulo 2*DEPTH.
  - count = wr_ptr - rd_ptr, computed modulo 2^(ADDRESS+1).
- Flags:
  - All flags are a combinational decode of the registered pointers/count.
  - Flags change in the cycle after the accepting edge.
- Write acceptance:
  - Accepted when i_wren && !o_full, evaluated before the edge.
  - On acceptance, memory[wr_ptr] <= i_wrdata and wr_ptr increments.
- Read acceptance:
  - Accepted when i_rden && !o_empty.
  - On acceptance, o_rddata <= memory[rd_ptr], rd_ptr increments, and o_rdvalid=1 the next cycle (1-cycle latency).
  - When no read is accepted, o_rdvalid=0 and o_rddata holds its last value.
- Simultaneous read and write:
  - Both are accepted when neither flag blocks; count is unchanged.
  - When full, only the read is accepted; the write is dropped and o_overflow is set.
  - When empty, only the write is accepted; the read is dropped and o_underflow is set.
  - A write to an empty FIFO is never read in the same cycle.
- Error flags:
  - o_overflow sets on i_wren && o_full; o_underflow sets on i_rden && o_empty.
  - Both are cleared by i_clr_err.
  - Set has priority over clear in the same cycle.
  - Dropped requests do not alter pointers or memory.
- Almost flags:
  - At the default parameters, o_alm_full=1 for count 1020..1024 and o_alm_empty=1 for count 0..2.

Optional Feature:
- Macro FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined:
  - o_rddata = memory[rd_ptr], combinational; o_rdvalid = !o_empty.
  - i_rden acts as a pop acknowledge, with 0-cycle latency.
  - Underflow rules and all flag rules are unchanged.
- Undefined: the standard registered read with 1-cycle latency described above.

Test Plan:
- Reset with DEPTH=16 -> o_empty=1, o_alm_empty=1, o_count=0, o_rddata=0, error flags 0.
- Write 16 words 0x1..0x10, then a 17th write of 0xFF -> o_full=1, o_count=16, o_overflow=1.
  - Follow with 16 reads: o_rddata must sequence 0x1..0x10 with o_rdvalid one cycle after each i_rden; 0xFF is never seen.
- DEPTH=16, AF_MARGIN=4, AE_MARGIN=2:
  - Fill one word per cycle: o_alm_empty deasserts when count goes 2->3; o_alm_full asserts when count reaches 12.
  - Drain symmetrically: the flags reverse at the same counts.
- Simultaneous i_wren and i_rden for 40 cycles starting at count=5 -> count stays 5 and FIFO order is preserved.
  - This exercises pointer wrap past 2*DEPTH.
- Read while empty with i_clr_err=1 in the same cycle -> o_underflow=1 (set wins).
  - Next cycle i_clr_err=1 alone -> o_underflow=0.
- Assert reset after writing 7 words -> o_count=0 and o_empty=1 next cycle.
  - A subsequent write of 0xAB followed by a read returns 0xAB.
